// File: rtl/acm_led_ctrl.sv
// Byte-stream command decoder ('L' load / 'Q' query) driving a 3-channel 8-bit LED PWM.
// New duties are staged in shadow registers and go live only at the PWM period boundary.
module acm_led_ctrl #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned TIMEOUT  = 1200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CmdLoad  = 8'h4C;
    localparam logic [7:0] CmdQuery = 8'h51;
    localparam logic [7:0] RspOk    = 8'h4B;
    localparam logic [7:0] RspErr   = 8'h45;

    typedef enum logic [3:0] {
        StIdle, StArgR, StArgG, StArgB, StSendK, StSendQ0, StSendQ1, StSendQ2, StSendE
    } state_e;

    state_e state_q, state_d;
    logic   live_q;

    logic [TW-1:0] tmo_q;
    logic [7:0]    tmp_r, tmp_g;
    logic [7:0]    shadow_r, shadow_g, shadow_b;
    logic [7:0]    duty_r, duty_g, duty_b;
    logic [7:0]    qry_r, qry_g, qry_b;
    logic [PW-1:0] presc_q;
    logic [7:0]    cnt_q;
    logic          pwm_r_q, pwm_g_q, pwm_b_q;

    logic rx_fire, tx_fire, in_arg, tmo_hit, step;

    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;
    assign in_arg  = state_q inside {StArgR, StArgG, StArgB};
    assign tmo_hit = tmo_q >= TW'(TIMEOUT);
    assign step    = presc_q == PW'(PRESCALE - 1);

    // State register; live_q holds rx_ready low until the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (rx_fire && rx_data == CmdLoad) begin
                    state_d = StArgR;
                end else if (rx_fire && rx_data == CmdQuery) begin
                    state_d = StSendQ0;
                end
            end
            StArgR: begin
                if (rx_fire) state_d = StArgG;
                else if (tmo_hit) state_d = StSendE;
            end
            StArgG: begin
                if (rx_fire) state_d = StArgB;
                else if (tmo_hit) state_d = StSendE;
            end
            StArgB: begin
                if (rx_fire) state_d = StSendK;
                else if (tmo_hit) state_d = StSendE;
            end
            StSendQ0: if (tx_fire) state_d = StSendQ1;
            StSendQ1: if (tx_fire) state_d = StSendQ2;
            StSendK, StSendQ2, StSendE: if (tx_fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_ready = live_q && (state_q == StIdle || in_arg);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            StSendK:  begin tx_valid = 1'b1; tx_data = RspOk;  end
            StSendE:  begin tx_valid = 1'b1; tx_data = RspErr; end
            StSendQ0: begin tx_valid = 1'b1; tx_data = qry_r;  end
            StSendQ1: begin tx_valid = 1'b1; tx_data = qry_g;  end
            StSendQ2: begin tx_valid = 1'b1; tx_data = qry_b;  end
            default:  ;
        endcase
    end

    // Frame datapath: argument capture, shadow load, inter-byte timeout, query snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q    <= '0;
            tmp_r    <= 8'h00;
            tmp_g    <= 8'h00;
            shadow_r <= 8'h00;
            shadow_g <= 8'h00;
            shadow_b <= 8'h00;
            qry_r    <= 8'h00;
            qry_g    <= 8'h00;
            qry_b    <= 8'h00;
        end else begin
            tmo_q <= (in_arg && !rx_fire) ? tmo_q + TW'(1) : '0;
            if (rx_fire && state_q == StArgR) tmp_r <= rx_data;
            if (rx_fire && state_q == StArgG) tmp_g <= rx_data;
            if (rx_fire && state_q == StArgB) begin
                shadow_r <= tmp_r;
                shadow_g <= tmp_g;
                shadow_b <= rx_data;
            end
            // Snapshot keeps tx_data stable even if a period wrap lands mid-reply.
            if (rx_fire && state_q == StIdle && rx_data == CmdQuery) begin
                qry_r <= duty_r;
                qry_g <= duty_g;
                qry_b <= duty_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= 8'h00;
            duty_r  <= 8'h00;
            duty_g  <= 8'h00;
            duty_b  <= 8'h00;
            pwm_r_q <= 1'b0;
            pwm_g_q <= 1'b0;
            pwm_b_q <= 1'b0;
        end else begin
            presc_q <= step ? '0 : presc_q + PW'(1);
            if (step) begin
                cnt_q <= cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    duty_r <= shadow_r;
                    duty_g <= shadow_g;
                    duty_b <= shadow_b;
                end
            end
            pwm_r_q <= cnt_q < duty_r;
            pwm_g_q <= cnt_q < duty_g;
            pwm_b_q <= cnt_q < duty_b;
        end
    end

    assign pwm_r = pwm_r_q;
    assign pwm_g = pwm_g_q;
    assign pwm_b = pwm_b_q;

endmodule
